// File: rtl/spi_sram_pkg.sv
// Shared definitions for the SPI serial-SRAM responder.
//   - Opcode constants of the 23LC-style command set
//   - Reset value of the status/mode register
//   - FSM state encoding (4 bits, exported on dbg_state)
package spi_sram_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WRSR  = 8'h01;

  localparam logic [7:0] SR_RESET_DEFAULT = 8'h40;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    CMD        = 4'd1,
    ADDR_HI    = 4'd2,
    ADDR_LO    = 4'd3,
    READ_DATA  = 4'd4,
    WRITE_DATA = 4'd5,
    STATUS_RD  = 4'd6,
    STATUS_WR  = 4'd7,
    IGNORE     = 4'd8
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus single-cycle
// rise/fall strobes derived from the synchronized level.
//   clk_i, reset_n_i : system clock, synchronous active-low reset
//   d_i              : asynchronous input
//   q_o              : synchronized level
//   rise_o / fall_o  : one-clk strobes on synchronized 0->1 / 1->0
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o =  sync_q & ~prev_q;
  assign fall_o = ~sync_q &  prev_q;

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 slave emulating a 23LC-style serial SRAM on top of a
// byte-wide synchronous RAM port. All SPI pins are oversampled in clk.
//   spi_cs_n/spi_sclk/spi_mosi : host pins (asynchronous)
//   spi_miso, spi_miso_oe      : serial data out and its drive enable
//   mem_addr/mem_wdata/mem_we/mem_re/mem_rdata : RAM port (rdata 1 clk after re)
//   busy      : synchronized chip select asserted
//   dbg_state : current FSM state
module spi_sram_responder
  import spi_sram_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter logic [7:0]  SR_RESET = SR_RESET_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic [3:0]        dbg_state
);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_meta_q, mosi_s_q;

  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk_i(clk), .reset_n_i(reset_n), .d_i(spi_cs_n),
    .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk_i(clk), .reset_n_i(reset_n), .d_i(spi_sclk),
    .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  state_e              state_q, state_d;
  logic [2:0]          bitcnt_q, bitcnt_d;
  logic [7:0]          rx_q, rx_d;
  logic [7:0]          tx_q, tx_d;
  logic [15:0]         addr_q, addr_d;
  logic                rd_q, rd_d;
  logic [7:0]          sr_q, sr_d;
  logic                sr_done_q, sr_done_d;
  logic                oe_q, oe_d;
  logic                load_q, load_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;

  logic        byte_done;
  logic [7:0]  rx_byte;
  logic [15:0] addr_inc, addr_full;

  assign byte_done = sclk_rise && (bitcnt_q == 3'd7);
  assign rx_byte   = {rx_q[6:0], mosi_s_q};
  assign addr_inc  = addr_q + 16'd1;
  assign addr_full = {addr_q[15:8], rx_byte};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mosi_meta_q <= 1'b0;
      mosi_s_q    <= 1'b0;
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      sr_q        <= SR_RESET;
      sr_done_q   <= 1'b0;
      oe_q        <= 1'b0;
      load_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mosi_meta_q <= spi_mosi;
      mosi_s_q    <= mosi_meta_q;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      sr_q        <= sr_d;
      sr_done_q   <= sr_done_d;
      oe_q        <= oe_d;
      load_q      <= load_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    sr_d        = sr_q;
    sr_done_d   = sr_done_q;
    oe_d        = oe_q;
    load_d      = 1'b0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (cs_s) begin
      // Deselect wins over a byte completing in the same clk.
      state_d  = IDLE;
      bitcnt_d = '0;
      oe_d     = 1'b0;
      if (cs_rise) rx_d = '0;
    end else begin
      load_d = mem_re_q;
      if (sclk_rise) begin
        bitcnt_d = bitcnt_q + 3'd1;
        rx_d     = rx_byte;
      end
      // No shift on the first fall after a byte boundary: the freshly
      // loaded MSB must stay on MISO until the host samples it.
      if (sclk_fall && (bitcnt_q != 3'd0)) tx_d = {tx_q[6:0], 1'b0};
      if (load_q && (state_q == READ_DATA)) begin
        tx_d = mem_rdata;
        oe_d = 1'b1;
      end

      unique case (state_q)
        IDLE: if (cs_fall) state_d = CMD;
        CMD: if (byte_done) begin
          case (rx_byte)
            OP_READ:  begin rd_d = 1'b1; state_d = ADDR_HI; end
            OP_WRITE: begin rd_d = 1'b0; state_d = ADDR_HI; end
            OP_RDSR:  begin tx_d = sr_q; oe_d = 1'b1; state_d = STATUS_RD; end
            OP_WRSR:  begin sr_done_d = 1'b0; state_d = STATUS_WR; end
            default:  state_d = IGNORE;
          endcase
        end
        ADDR_HI: if (byte_done) begin
          addr_d  = {rx_byte, addr_q[7:0]};
          state_d = ADDR_LO;
        end
        ADDR_LO: if (byte_done) begin
          addr_d = addr_full;
          if (rd_q) begin
            mem_re_d   = 1'b1;
            mem_addr_d = addr_full[ADDR_W-1:0];
            state_d    = READ_DATA;
          end else begin
            state_d = WRITE_DATA;
          end
        end
        READ_DATA: if (byte_done) begin
          addr_d     = addr_inc;
          mem_re_d   = 1'b1;
          mem_addr_d = addr_inc[ADDR_W-1:0];
        end
        WRITE_DATA: if (byte_done) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q[ADDR_W-1:0];
          mem_wdata_d = rx_byte;
          addr_d      = addr_inc;
        end
        STATUS_RD: if (byte_done) tx_d = sr_q;
        STATUS_WR: if (byte_done && !sr_done_q) begin
          sr_d      = rx_byte;
          sr_done_d = 1'b1;
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign spi_miso    = oe_q & tx_q[7];
  assign spi_miso_oe = oe_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_re      = mem_re_q;
  assign busy        = ~cs_s;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
module tb_spi_sram_responder;

  localparam int HALF = 6;  // clk cycles per SCLK phase

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_cs_n = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, mem_re, busy;
  logic [3:0]  dbg_state;

  always #5 clk = ~clk;

  spi_sram_responder #(.ADDR_W(16), .SR_RESET(8'h40)) dut (
    .clk(clk), .reset_n(reset_n), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // Backing RAM seen by the DUT
  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  // Reference model: memory image and status register
  logic [7:0] ref_mem [0:65535];
  logic [7:0] sr_model;

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t         exp_wr_q[$];
  logic [15:0] exp_rd_q[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT strobes the RAM port
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_we && mem_re) begin
        checks++; failures++;
        $display("FAIL we_re_overlap actual=both expected=exclusive");
      end
      if (mem_we) begin
        if (exp_wr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_we actual=%0h:%0h expected=none", mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = exp_wr_q.pop_front();
          check("we_addr", {16'd0, mem_addr}, {16'd0, e.a});
          check("we_data", {24'd0, mem_wdata}, {24'd0, e.d});
        end
      end
      if (mem_re) begin
        if (exp_rd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_re actual=%0h expected=none", mem_addr);
        end else begin
          logic [15:0] ea;
          ea = exp_rd_q.pop_front();
          check("re_addr", {16'd0, mem_addr}, {16'd0, ea});
        end
      end
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r,
                          output logic oe_any, output logic oe_all);
    r = '0; oe_any = 1'b0; oe_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      repeat (HALF) @(negedge clk);
      r[7-i] = spi_miso;
      oe_any = oe_any | spi_miso_oe;
      oe_all = oe_all & spi_miso_oe;
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r,
                          output logic oe_any, output logic oe_all);
    spi_bits(b, 8, r, oe_any, oe_all);
  endtask

  task automatic cs_start();
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [15:0] a, input bit is_read);
    logic [7:0] r; logic oa, ol;
    spi_byte(op, r, oa, ol);      check("hdr_oe_op", {31'd0, oa}, 0);
    spi_byte(a[15:8], r, oa, ol); check("hdr_oe_hi", {31'd0, oa}, 0);
    if (is_read) exp_rd_q.push_back(a);
    spi_byte(a[7:0], r, oa, ol);  check("hdr_oe_lo", {31'd0, oa}, 0);
  endtask

  task automatic do_write(input logic [15:0] a, input int n, input logic [7:0] d0, input logic [7:0] d1,
                          input bit use_fixed);
    logic [7:0] r, d; logic oa, ol; logic [15:0] wa;
    cs_start();
    send_hdr(8'h02, a, 1'b0);
    for (int i = 0; i < n; i++) begin
      d = use_fixed ? ((i == 0) ? d0 : d1) : 8'($urandom);
      wa = a + 16'(i);
      exp_wr_q.push_back('{a: wa, d: d});
      ref_mem[wa] = d;
      spi_byte(d, r, oa, ol);
    end
    cs_end();
  endtask

  task automatic do_read(input logic [15:0] a, input int n);
    logic [7:0] r; logic oa, ol;
    cs_start();
    send_hdr(8'h03, a, 1'b1);
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(a + 16'(i + 1));
      spi_byte(8'($urandom), r, oa, ol);
      check("rd_data", {24'd0, r}, {24'd0, ref_mem[a + 16'(i)]});
      check("rd_oe", {31'd0, ol}, 1);
    end
    cs_end();
  endtask

  task automatic do_rdsr(input int n);
    logic [7:0] r; logic oa, ol;
    cs_start();
    spi_byte(8'h05, r, oa, ol);
    check("rdsr_cmd_oe", {31'd0, oa}, 0);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'($urandom), r, oa, ol);
      check("rdsr_data", {24'd0, r}, {24'd0, sr_model});
    end
    cs_end();
  endtask

  task automatic do_wrsr(input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] r; logic oa, ol;
    cs_start();
    spi_byte(8'h01, r, oa, ol);
    spi_byte(b0, r, oa, ol);
    spi_byte(b1, r, oa, ol);
    sr_model = b0;  // only the first byte of the frame lands
    cs_end();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r; logic oa, ol; logic [15:0] a; int n;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    sr_model = 8'h40;
    repeat (4) @(negedge clk);
    check("reset_outputs", {14'd0, spi_miso, spi_miso_oe, mem_addr, mem_wdata, mem_we, mem_re, busy, dbg_state},
          32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    do_write(16'h0010, 2, 8'hA5, 8'h3C, 1'b1);
    do_read(16'h0010, 2);
    do_write(16'hFFFF, 2, 8'h11, 8'h22, 1'b1);
    do_read(16'hFFFF, 2);

    do_rdsr(2);
    do_wrsr(8'h00, 8'h55);
    do_rdsr(2);

    // Aborted write: 5 data bits then deselect
    cs_start();
    send_hdr(8'h02, 16'h0020, 1'b0);
    spi_bits(8'hFF, 5, r, oa, ol);
    cs_end();
    do_read(16'h0020, 1);

    // Unknown opcode
    cs_start();
    spi_byte(8'h9F, r, oa, ol);
    for (int i = 0; i < 2; i++) begin
      spi_byte(8'($urandom), r, oa, ol);
      check("ign_miso", {24'd0, r}, 0);
      check("ign_oe", {31'd0, oa}, 0);
    end
    cs_end();

    // Reset in the middle of a read
    cs_start();
    send_hdr(8'h03, 16'h0100, 1'b1);
    exp_rd_q.push_back(16'h0101);
    spi_byte(8'h00, r, oa, ol);
    check("pre_reset_rd", {24'd0, r}, {24'd0, ref_mem[16'h0100]});
    spi_bits(8'h00, 4, r, oa, ol);
    reset_n = 1'b0;
    @(negedge clk);
    check("midread_reset_outputs",
          {14'd0, spi_miso, spi_miso_oe, mem_addr, mem_wdata, mem_we, mem_re, busy, dbg_state}, 32'd0);
    spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    sr_model = 8'h40;
    repeat (4) @(negedge clk);
    do_rdsr(1);
    do_read(16'h0010, 2);

    // Randomized traffic
    for (int k = 0; k < 8; k++) begin
      a = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom);
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) do_write(a, n, 8'h00, 8'h00, 1'b0);
      do_read(a, n);
    end

    repeat (20) @(negedge clk);
    check("wr_queue_drained", exp_wr_q.size(), 0);
    check("rd_queue_drained", exp_rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_sram_responder.md
Name: spi_sram_responder

Overview:
- Synthesizable SPI slave that emulates a 23LC-style serial SRAM, backed by a byte-wide synchronous RAM port.
- It is the responder end of the link driven by the CPU-side SPI memory controller. It replaces the behavioural SRAM model in FPGA/silicon builds and lets an external SPI host load and inspect memory.
- SPI mode 0 only: MOSI is sampled on SCLK rise, MISO changes on SCLK fall, MSB first.
- All SPI pins are oversampled in the `clk` domain.

Parameters:
- ADDR_W, 16, RAM address width. The protocol always carries a 16-bit address; only the low ADDR_W bits are used.
- SR_RESET, 8'h40, reset value of the status/mode register (sequential mode).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active low
- spi_cs_n  in  1  chip select from host, async, active low
- spi_sclk  in  1  serial clock from host, async
- spi_mosi  in  1  serial data in, async
- spi_miso  out  1  serial data out; driven 0 when not transmitting
- spi_miso_oe  out  1  high while a byte is being shifted out (READ/RDSR data phase)
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  8  RAM write data
- mem_we  out  1  single-cycle write strobe
- mem_re  out  1  single-cycle read strobe
- mem_rdata  in  8  read data, valid exactly 1 clk after mem_re
- busy  out  1  high while CS is asserted (synchronized)
- dbg_state  out  4  current FSM state encoding

Behaviour:
- Reset (reset_n=0 at clk rise):
  - state=IDLE; all outputs 0; status register=SR_RESET.
  - Shift registers, bit counter and address cleared.
  - Reset overrides any transaction in progress.
- Input synchronization:
  - cs_n, sclk and mosi each pass through a 2-FF synchronizer.
  - Rise/fall strobes come from the synchronized sclk vs its previous value.
  - mosi is sampled with the same delay as sclk.
- Clock ratio: f_sclk ≤ f_clk/8 is required. Each SCLK high and low phase must be ≥ 4 clk.
- Synchronized cs_n high: state→IDLE immediately and the bit counter clears. A partially received byte is discarded (no mem_we), and spi_miso/spi_miso_oe go to 0.
- Bit counter: 3 bits, increments on each sclk rise while CS is low; a byte completes when it wraps 7→0.
- FSM transitions on byte complete:
  - IDLE→CMD on cs_n falling.
  - CMD: opcode 0x03→ADDR_HI (read), 0x02→ADDR_HI (write), 0x05→STATUS_RD, 0x01→STATUS_WR, anything else→IGNORE.
  - ADDR_HI→ADDR_LO.
  - ADDR_LO→READ_DATA or WRITE_DATA, per the latched opcode.
- READ_DATA:
  - On the sclk rise that completes ADDR_LO, pulse mem_re with mem_addr=addr.
  - 1 clk later load mem_rdata into the tx shift register and set spi_miso_oe=1, driving bit 7 on spi_miso before the next SCLK fall.
  - On each sclk fall, shift left and drive the next bit.
  - On the sclk rise of bit 0 of the current byte (counter 7→0), increment addr, pulse mem_re, and load the next byte 1 clk later. The next byte's MSB is on MISO by the following fall.
  - Continues indefinitely until CS goes high.
- WRITE_DATA: on byte complete, pulse mem_we for 1 clk with mem_addr=addr and mem_wdata=received byte, then increment addr.
- Address arithmetic: modulo 2^ADDR_W; 0xFFFF+1 wraps to 0x0000. The upper (16−ADDR_W) address bits received are ignored.
- STATUS_RD: load the status register into the tx shift register immediately. The value is repeated on every subsequent byte.
- STATUS_WR: the first complete byte is written to the status register; later bytes are ignored. Addressing is always sequential regardless of mode bits.
- IGNORE: no memory access; spi_miso stays 0 until CS goes high.
- Simultaneous events:
  - cs_n rising has priority over a completing byte. If both are seen in the same clk, no mem_we occurs.
  - mem_we and mem_re are never asserted in the same cycle.

Decomposition:
- Package spi_sram_pkg:
  - opcode constants OP_READ=8'h03, OP_WRITE=8'h02, OP_RDSR=8'h05, OP_WRSR=8'h01;
  - state enum (IDLE, CMD, ADDR_HI, ADDR_LO, READ_DATA, WRITE_DATA, STATUS_RD, STATUS_WR, IGNORE) as a 4-bit typedef;
  - SR_RESET default.
- Sub-module spi_sync_edge: 2-FF synchronizer plus rise/fall strobe generation. Instantiated for sclk and cs_n; mosi uses the synchronizer only.

Test Plan:
1. WRITE 0x02, addr 0x0010, data A5, 3C, then CS high → exactly two mem_we pulses: (0x0010, A5), then (0x0011, 3C).
2. RAM preloaded with 0x0010=A5 and 0x0011=3C; READ 0x03 addr 0x0010, 16 data clocks → MISO shifts A5 then 3C MSB first. mem_re addresses are 0x0010, 0x0011, 0x0012 (prefetch). spi_miso_oe is high only during the data phase.
3. WRITE at addr 0xFFFF, data 11, 22 → mem_we at 0xFFFF (11), then at 0x0000 (22).
4. After reset, RDSR → 0x40. WRSR 0x00, then RDSR → 0x00. A second WRSR byte in the same frame is ignored.
5. WRITE cmd and addr 0x0020, then 5 data bits, then CS high → no mem_we. A following READ of 0x0020 returns the RAM's original contents.
6. Opcode 0x9F plus 16 clocks → MISO stays 0 and there is no mem_re/mem_we. reset_n=0 mid-READ → all outputs are 0 the next clk, and a subsequent READ works normally.
